// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the sdram_controller host port.
// Captures the winning request, holds it on h_* until h_compl, then acks that port for one cycle.
module sdram_arbiter #(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        a_req,
  input  logic [30:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic        a_wr_en,
  input  logic [1:0]  a_bytesel,
  output logic        a_ack,
  output logic [15:0] a_rdata,

  input  logic        b_req,
  input  logic [30:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic        b_wr_en,
  input  logic [1:0]  b_bytesel,
  output logic        b_ack,
  output logic [15:0] b_rdata,

  output logic [30:0] h_addr,
  output logic [15:0] h_wdata,
  output logic        h_wr_en,
  output logic [1:0]  h_bytesel,
  input  logic [15:0] h_rdata,
  input  logic        h_compl,
  input  logic        h_config_done
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q;
  logic   grant_b_q;
  logic   last_b_q;

  logic        pick_b;
  logic [30:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_wr_en;
  logic [1:0]  sel_bytesel;

  // On a tie, round-robin favours the port that was not granted last.
  always_comb begin
    pick_b = b_req;
    if (a_req && b_req) begin
      pick_b = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_b_q;
    end
  end

  always_comb begin
    sel_addr    = pick_b ? b_addr    : a_addr;
    sel_wdata   = pick_b ? b_wdata   : a_wdata;
    sel_wr_en   = pick_b ? b_wr_en   : a_wr_en;
    sel_bytesel = pick_b ? b_bytesel : a_bytesel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      grant_b_q <= 1'b0;
      last_b_q  <= 1'b1;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      h_addr    <= '0;
      h_wdata   <= '0;
      h_wr_en   <= 1'b0;
      h_bytesel <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          h_bytesel <= '0;
          if (h_config_done && (a_req || b_req)) begin
            grant_b_q <= pick_b;
            h_addr    <= sel_addr;
            h_wdata   <= sel_wdata;
            h_wr_en   <= sel_wr_en;
            if (sel_bytesel != 2'b00) begin
              h_bytesel <= sel_bytesel;
              state_q   <= StBusy;
            end else begin
              // Empty access: complete without touching the controller.
              last_b_q <= pick_b;
              a_ack    <= ~pick_b;
              b_ack    <= pick_b;
              state_q  <= StDone;
            end
          end
        end
        StBusy: begin
          if (h_compl) begin
            if (!h_wr_en) begin
              if (grant_b_q) b_rdata <= h_rdata;
              else           a_rdata <= h_rdata;
            end
            last_b_q  <= grant_b_q;
            h_bytesel <= '0;
            a_ack     <= ~grant_b_q;
            b_ack     <= grant_b_q;
            state_q   <= StDone;
          end
        end
        StDone: begin
          h_bytesel <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter; a second instance with FIXED_PRIORITY = 1 runs in lockstep.
module tb_sdram_arbiter;

  logic        clk;
  logic        reset_n;
  logic        a_req, b_req;
  logic [30:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_wr_en, b_wr_en;
  logic [1:0]  a_bytesel, b_bytesel;
  logic        a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic [30:0] h_addr;
  logic [15:0] h_wdata;
  logic        h_wr_en;
  logic [1:0]  h_bytesel;
  logic [15:0] h_rdata;
  logic        h_compl;
  logic        h_config_done;

  logic        fp_a_ack, fp_b_ack;
  logic [15:0] fp_a_rdata, fp_b_rdata;
  logic [30:0] fp_h_addr;
  logic [15:0] fp_h_wdata;
  logic        fp_h_wr_en;
  logic [1:0]  fp_h_bytesel;

  int checks = 0;
  int errors = 0;

  sdram_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_wr_en(a_wr_en),
    .a_bytesel(a_bytesel), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_wr_en(b_wr_en),
    .b_bytesel(b_bytesel), .b_ack(b_ack), .b_rdata(b_rdata),
    .h_addr(h_addr), .h_wdata(h_wdata), .h_wr_en(h_wr_en), .h_bytesel(h_bytesel),
    .h_rdata(h_rdata), .h_compl(h_compl), .h_config_done(h_config_done)
  );

  sdram_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_wr_en(a_wr_en),
    .a_bytesel(a_bytesel), .a_ack(fp_a_ack), .a_rdata(fp_a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_wr_en(b_wr_en),
    .b_bytesel(b_bytesel), .b_ack(fp_b_ack), .b_rdata(fp_b_rdata),
    .h_addr(fp_h_addr), .h_wdata(fp_h_wdata), .h_wr_en(fp_h_wr_en), .h_bytesel(fp_h_bytesel),
    .h_rdata(h_rdata), .h_compl(h_compl), .h_config_done(h_config_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (h_bytesel == 2'b00 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (h_bytesel == 2'b00) begin
      errors++;
      $display("FAIL wait_busy: h_bytesel=%0h, required nonzero within 20 cycles", h_bytesel);
    end
  endtask

  task automatic complete(input logic [15:0] data);
    h_rdata = data;
    h_compl = 1'b1;
    step();
    h_compl = 1'b0;
    h_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0; h_compl = 1'b0; h_rdata = '0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    bit bad = 0;
    reset_n = 1'b0;
    h_config_done = 1'b0;
    a_req = 1'b1; a_addr = 31'h100; a_bytesel = 2'b11; a_wr_en = 1'b0; a_wdata = 16'h5555;
    step();
    checks++;
    if ({a_ack, b_ack, a_rdata, b_rdata, h_addr, h_wdata, h_wr_en, h_bytesel} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: a_ack=%b b_ack=%b h_bytesel=%0h h_addr=%0h, required all 0",
               a_ack, b_ack, h_bytesel, h_addr);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (h_bytesel !== 2'b00 || a_ack !== 1'b0 || b_ack !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL config_hold: saw h_bytesel/ack activity before h_config_done, required none");
    end
    a_req = 1'b0;
    step();
  endtask

  task automatic test_read();
    h_config_done = 1'b1;
    a_req = 1'b1; a_addr = 31'h100; a_bytesel = 2'b11; a_wr_en = 1'b0;
    wait_busy();
    checks++;
    if (h_addr !== 31'h100 || h_bytesel !== 2'b11 || h_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL read_cmd: h_addr=%0h h_bytesel=%0h h_wr_en=%b, required 100/3/0",
               h_addr, h_bytesel, h_wr_en);
    end
    step();
    step();
    complete(16'hBEEF);
    checks++;
    if (a_ack !== 1'b1 || b_ack !== 1'b0 || a_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_ack: a_ack=%b b_ack=%b a_rdata=%h, required 1/0/beef",
               a_ack, b_ack, a_rdata);
    end
    a_req = 1'b0;
    step();
    checks++;
    if (a_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_ack_pulse: a_ack=%b, required 0 after one cycle", a_ack);
    end
  endtask

  task automatic test_round_robin();
    logic        exp_b;
    logic [15:0] d;
    do_reset();
    a_req = 1'b1; a_addr = 31'h0A0A; a_wdata = '0; a_wr_en = 1'b0; a_bytesel = 2'b11;
    b_req = 1'b1; b_addr = 31'h0B0B; b_wdata = '0; b_wr_en = 1'b0; b_bytesel = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_b = (k % 2) == 1;
      d = 16'h1000 + 16'(k);
      wait_busy();
      checks++;
      if (h_addr !== (exp_b ? 31'h0B0B : 31'h0A0A)) begin
        errors++;
        $display("FAIL rr_addr[%0d]: h_addr=%0h, required %0h", k, h_addr,
                 exp_b ? 31'h0B0B : 31'h0A0A);
      end
      checks++;
      if (fp_h_addr !== 31'h0A0A || fp_h_bytesel !== 2'b11 || {fp_h_wr_en, fp_h_wdata} !== '0)
      begin
        errors++;
        $display("FAIL fp_cmd[%0d]: h_addr=%0h h_bytesel=%0h, required a0a/3", k, fp_h_addr,
                 fp_h_bytesel);
      end
      step();
      complete(d);
      checks++;
      if (a_ack !== ~exp_b || b_ack !== exp_b) begin
        errors++;
        $display("FAIL rr_grant[%0d]: a_ack=%b b_ack=%b, required %b/%b", k, a_ack, b_ack,
                 ~exp_b, exp_b);
      end
      checks++;
      if ((exp_b ? b_rdata : a_rdata) !== d) begin
        errors++;
        $display("FAIL rr_rdata[%0d]: rdata=%h, required %h", k, exp_b ? b_rdata : a_rdata, d);
      end
      checks++;
      if (fp_a_ack !== 1'b1 || fp_b_ack !== 1'b0 || fp_a_rdata !== d || fp_b_rdata !== 16'h0)
      begin
        errors++;
        $display("FAIL fp_grant[%0d]: a_ack=%b b_ack=%b a_rdata=%h, required 1/0/%h", k,
                 fp_a_ack, fp_b_ack, fp_a_rdata, d);
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    step();
  endtask

  task automatic test_b_write();
    bit bad = 0;
    b_req = 1'b1; b_addr = 31'h55; b_wdata = 16'h1234; b_bytesel = 2'b01; b_wr_en = 1'b1;
    wait_busy();
    // Port inputs change while granted; the captured access must not move.
    b_addr = 31'h7FFF; b_wdata = 16'h0; b_bytesel = 2'b11; b_wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (h_addr !== 31'h55 || h_wdata !== 16'h1234 || h_bytesel !== 2'b01 || h_wr_en !== 1'b1)
        bad = 1;
      step();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL write_stable: h_addr=%0h h_wdata=%h h_bytesel=%0h h_wr_en=%b, required 55/1234/1/1",
               h_addr, h_wdata, h_bytesel, h_wr_en);
    end
    complete(16'hDEAD);
    checks++;
    if (b_ack !== 1'b1 || a_ack !== 1'b0 || h_bytesel !== 2'b00) begin
      errors++;
      $display("FAIL write_done: b_ack=%b a_ack=%b h_bytesel=%0h, required 1/0/0",
               b_ack, a_ack, h_bytesel);
    end
    checks++;
    if (b_rdata !== 16'h1003) begin
      errors++;
      $display("FAIL write_rdata: b_rdata=%h, required 1003 (unchanged by write)", b_rdata);
    end
    b_req = 1'b0;
    step();
  endtask

  task automatic test_zero_bytesel();
    a_req = 1'b1; a_addr = 31'h200; a_bytesel = 2'b00; a_wr_en = 1'b0;
    h_rdata = 16'h7777;
    checks++;
    if (a_ack !== 1'b0) begin
      errors++;
      $display("FAIL zero_pre: a_ack=%b, required 0 in request cycle", a_ack);
    end
    step();
    checks++;
    if (a_ack !== 1'b1 || h_bytesel !== 2'b00 || a_rdata !== 16'h1002) begin
      errors++;
      $display("FAIL zero_ack: a_ack=%b h_bytesel=%0h a_rdata=%h, required 1/0/1002",
               a_ack, h_bytesel, a_rdata);
    end
    a_req = 1'b0;
    step();
    checks++;
    if (a_ack !== 1'b0 || h_bytesel !== 2'b00) begin
      errors++;
      $display("FAIL zero_post: a_ack=%b h_bytesel=%0h, required 0/0", a_ack, h_bytesel);
    end
    h_rdata = '0;
  endtask

  task automatic test_reset_mid();
    a_req = 1'b1; a_addr = 31'h300; a_bytesel = 2'b11; a_wr_en = 1'b0;
    wait_busy();
    step();
    reset_n = 1'b0;
    a_req = 1'b0;
    #1;
    checks++;
    if (h_bytesel !== 2'b00 || a_ack !== 1'b0 || a_rdata !== 16'h0) begin
      errors++;
      $display("FAIL midreset_async: h_bytesel=%0h a_ack=%b a_rdata=%h, required 0/0/0",
               h_bytesel, a_ack, a_rdata);
    end
    step();
    reset_n = 1'b1;
    complete(16'hAAAA);
    checks++;
    if (a_ack !== 1'b0 || b_ack !== 1'b0 || h_bytesel !== 2'b00 || a_rdata !== 16'h0) begin
      errors++;
      $display("FAIL stray_compl: a_ack=%b b_ack=%b h_bytesel=%0h a_rdata=%h, required 0/0/0/0",
               a_ack, b_ack, h_bytesel, a_rdata);
    end
    step();
    b_req = 1'b1; b_addr = 31'h400; b_bytesel = 2'b11; b_wr_en = 1'b0;
    wait_busy();
    checks++;
    if (h_addr !== 31'h400 || h_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_cmd: h_addr=%0h h_wr_en=%b, required 400/0", h_addr, h_wr_en);
    end
    complete(16'h4321);
    checks++;
    if (b_ack !== 1'b1 || a_ack !== 1'b0 || b_rdata !== 16'h4321) begin
      errors++;
      $display("FAIL post_reset_ack: b_ack=%b a_ack=%b b_rdata=%h, required 1/0/4321",
               b_ack, a_ack, b_rdata);
    end
    b_req = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0; h_config_done = 1'b0; h_compl = 1'b0; h_rdata = '0;
    a_req = 1'b0; a_addr = '0; a_wdata = '0; a_wr_en = 1'b0; a_bytesel = '0;
    b_req = 1'b0; b_addr = '0; b_wdata = '0; b_wr_en = 1'b0; b_bytesel = '0;
    test_reset();
    test_read();
    test_round_robin();
    test_b_write();
    test_zero_bytesel();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
